// File: rtl/light_strip_tx.sv
// Serialises 24-bit colour words onto a single-wire, pulse-width-coded LED strip line.
// Handshake: a word transfers on a rising edge where light_valid && light_ready; light_ready is registered.
module light_strip_tx #(
  parameter int unsigned T0H          = 35,
  parameter int unsigned T0L          = 80,
  parameter int unsigned T1H          = 70,
  parameter int unsigned T1L          = 60,
  parameter int unsigned LATCH_CYCLES = 5000,
  parameter int          CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] light,
  input  logic        light_valid,
  input  logic        light_last,
  output logic        light_ready,
  output logic        dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       idx_q, idx_d;
  logic             last_q, last_d;
  logic             dout_q;
  logic             ready_q, ready_d;
  logic             xfer;
  logic             phase_end;

  function automatic logic [CNT_W-1:0] high_len(input logic b);
    return b ? CNT_W'(T1H) : CNT_W'(T0H);
  endfunction

  function automatic logic [CNT_W-1:0] low_len(input logic b);
    return b ? CNT_W'(T1L) : CNT_W'(T0L);
  endfunction

  assign xfer      = light_valid && ready_q;
  assign phase_end = (cnt_q == CNT_ONE);

  // cnt_q holds the cycles remaining in the current phase, including this one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          shift_d = light;
          last_d  = light_last;
          idx_d   = 5'd23;
          cnt_d   = high_len(light[23]);
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_d   = low_len(shift_q[23]);
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_LOW: begin
        if (!phase_end) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (idx_q != 5'd0) begin
          idx_d   = idx_q - 5'd1;
          shift_d = {shift_q[22:0], 1'b0};
          cnt_d   = high_len(shift_q[22]);
          state_d = S_HIGH;
        end else if (last_q) begin
          cnt_d   = CNT_W'(LATCH_CYCLES);
          state_d = S_LATCH;
        end else if (xfer) begin
          // Next word starts directly after bit 0 with no idle gap.
          shift_d = light;
          last_d  = light_last;
          idx_d   = 5'd23;
          cnt_d   = high_len(light[23]);
          state_d = S_HIGH;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Ready is decoded from next-state values so it can be registered yet line up with the final LOW cycle.
  always_comb begin
    ready_d = (state_d == S_IDLE) ||
              ((state_d == S_LOW) && (cnt_d == CNT_ONE) && (idx_d == 5'd0) && !last_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      dout_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      dout_q  <= (state_d == S_HIGH);
      ready_q <= ready_d;
    end
  end

  assign dout        = dout_q;
  assign light_ready = ready_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_light_strip_tx.sv
// Bench for light_strip_tx: per-cycle {light_ready, busy, dout} compared against a waveform
// built from the bit-timing rules for each word, its last flag and the idle/latch periods.
module tb_light_strip_tx;

  localparam int T0H   = 2;
  localparam int T0L   = 4;
  localparam int T1H   = 4;
  localparam int T1L   = 2;
  localparam int LATCH = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] light;
  logic        light_valid;
  logic        light_last;
  logic        light_ready;
  logic        dout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [2:0]  exp_q[$];
  logic [2:0]  act_q[$];
  logic [23:0] wq[$];
  logic        lq[$];

  light_strip_tx #(
    .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .LATCH_CYCLES(LATCH), .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .light      (light),
    .light_valid(light_valid),
    .light_last (light_last),
    .light_ready(light_ready),
    .dout       (dout),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  // reference model: expected {ready, busy, dout} for each cycle
  task automatic model_word(input logic [23:0] w, input logic l);
    int  th, tl;
    logic r;
    for (int b = 23; b >= 0; b--) begin
      th = w[b] ? T1H : T0H;
      tl = w[b] ? T1L : T0L;
      repeat (th) exp_q.push_back(3'b011);
      for (int j = 0; j < tl; j++) begin
        r = (b == 0) && (j == tl - 1) && !l;
        exp_q.push_back({r, 1'b1, 1'b0});
      end
    end
    if (l) repeat (LATCH) exp_q.push_back(3'b010);
  endtask

  task automatic model_idle(input int n);
    repeat (n) exp_q.push_back(3'b100);
  endtask

  // model a stream of words presented with valid held until each is taken
  task automatic model_stream(input int tail);
    for (int k = 0; k < wq.size(); k++) begin
      model_word(wq[k], lq[k]);
      if (lq[k] && (k + 1 < wq.size())) model_idle(1);
    end
    model_idle(tail);
  endtask

  // driver
  task automatic present();
    if (wq.size() > 0) begin
      light_valid = 1'b1;
      light       = wq[0];
      light_last  = lq[0];
    end else begin
      light_valid = 1'b0;
      light       = 24'($urandom);
      light_last  = 1'($urandom);
    end
  endtask

  task automatic drive_stream(input int n);
    logic took;
    present();
    for (int i = 0; i < n; i++) begin
      took = light_valid && light_ready;
      @(negedge clk);
      if (took) begin
        void'(wq.pop_front());
        void'(lq.pop_front());
      end
      present();
      act_q.push_back({light_ready, busy, dout});
    end
  endtask

  function automatic int diff_streams(output int first);
    int m;
    m = 0;
    first = -1;
    for (int i = 0; i < act_q.size(); i++) begin
      if (i >= exp_q.size() || act_q[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        m++;
      end
    end
    return m;
  endfunction

  task automatic clear_q();
    exp_q.delete();
    act_q.delete();
    wq.delete();
    lq.delete();
  endtask

  // tests
  task automatic test_reset();
    int m, f;
    rst_n = 1'b1;
    light_valid = 1'b1;
    light = 24'hFFFFFF;
    light_last = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    tests++; if (dout !== 1'b0) begin fails++; $display("FAIL reset_dout: got %b want 0", dout); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (light_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", light_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (light_ready !== 1'b1) begin fails++; $display("FAIL ready_after_release: got %b want 1", light_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_release: got %b want 0", busy); end
    tests++; if (dout !== 1'b0) begin fails++; $display("FAIL dout_after_release: got %b want 0", dout); end
    clear_q();
    model_idle(10);
    drive_stream(exp_q.size());
    m = diff_streams(f);
    tests++;
    if (m !== 0) begin
      fails++;
      $display("FAIL reset_idle: %0d bad cycles, first %0d got %b want %b", m, f, act_q[f], exp_q[f]);
    end
  endtask

  task automatic test_single_word();
    int m, f;
    clear_q();
    wq.push_back(24'h800001); lq.push_back(1'b0);
    model_stream(4);
    drive_stream(exp_q.size());
    m = diff_streams(f);
    tests++;
    if (m !== 0) begin
      fails++;
      $display("FAIL single_word: %0d bad cycles, first %0d got %b want %b", m, f, act_q[f], exp_q[f]);
    end
  endtask

  task automatic test_back_to_back();
    int m, f;
    for (int it = 0; it < 2; it++) begin
      clear_q();
      wq.push_back(it == 0 ? 24'hFFFFFF : 24'($urandom)); lq.push_back(1'b0);
      wq.push_back(it == 0 ? 24'h000000 : 24'($urandom)); lq.push_back(1'b0);
      model_stream(3);
      drive_stream(exp_q.size());
      m = diff_streams(f);
      tests++;
      if (m !== 0) begin
        fails++;
        $display("FAIL back_to_back[%0d]: %0d bad cycles, first %0d got %b want %b", it, m, f, act_q[f], exp_q[f]);
      end
    end
  endtask

  task automatic test_latch();
    int m, f;
    for (int it = 0; it < 2; it++) begin
      clear_q();
      wq.push_back(it == 0 ? 24'h00FF00 : 24'($urandom)); lq.push_back(1'b1);
      wq.push_back(24'($urandom)); lq.push_back(1'b0);
      model_stream(3);
      drive_stream(exp_q.size());
      m = diff_streams(f);
      tests++;
      if (m !== 0) begin
        fails++;
        $display("FAIL latch[%0d]: %0d bad cycles, first %0d got %b want %b", it, m, f, act_q[f], exp_q[f]);
      end
    end
  endtask

  task automatic test_random_streams();
    int m, f, nw;
    for (int it = 0; it < 5; it++) begin
      clear_q();
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        wq.push_back(24'($urandom));
        lq.push_back(1'($urandom));
      end
      model_stream($urandom_range(1, 4));
      drive_stream(exp_q.size());
      m = diff_streams(f);
      tests++;
      if (m !== 0) begin
        fails++;
        $display("FAIL random_stream[%0d]: %0d bad cycles, first %0d got %b want %b", it, m, f, act_q[f], exp_q[f]);
      end
    end
  endtask

  task automatic test_stall();
    int m, f;
    clear_q();
    model_idle(20);
    drive_stream(exp_q.size());
    m = diff_streams(f);
    tests++;
    if (m !== 0) begin
      fails++;
      $display("FAIL stall: %0d bad cycles, first %0d got %b want %b", m, f, act_q[f], exp_q[f]);
    end
  endtask

  task automatic test_reset_mid_word();
    int m, f;
    clear_q();
    wq.push_back(24'($urandom) | 24'h008000); lq.push_back(1'b0);
    model_stream(0);
    // bits 23..16 take 48 cycles; cycle 49 is inside the 4-cycle HIGH of bit 15
    drive_stream(50);
    m = diff_streams(f);
    tests++;
    if (m !== 0) begin
      fails++;
      $display("FAIL pre_reset_word: %0d bad cycles, first %0d got %b want %b", m, f, act_q[f], exp_q[f]);
    end
    rst_n = 1'b0;
    #1;
    tests++; if (dout !== 1'b0) begin fails++; $display("FAIL midreset_dout: got %b want 0", dout); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
    tests++; if (light_ready !== 1'b0) begin fails++; $display("FAIL midreset_ready: got %b want 0", light_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (light_ready !== 1'b1) begin fails++; $display("FAIL midreset_release_ready: got %b want 1", light_ready); end
    clear_q();
    wq.push_back(24'h000001); lq.push_back(1'b0);
    model_stream(3);
    drive_stream(exp_q.size());
    m = diff_streams(f);
    tests++;
    if (m !== 0) begin
      fails++;
      $display("FAIL post_reset_word: %0d bad cycles, first %0d got %b want %b", m, f, act_q[f], exp_q[f]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_latch();
    test_stall();
    test_random_streams();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
